alu4_arbiter: RTL and testbench

ALU4_ARBITER -- requirements
Module: alu4_arbiter

---
 rtl/alu4_arbiter_pkg.sv | 25 ++
 rtl/alu4_arbiter_alu4bit.sv | 44 ++++
 rtl/alu4_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu4_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu4_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// alu4_arbiter_pkg
//   Shared constants for the two-requester ALU arbiter and its 4-bit ALU:
//   opcode encodings, FSM state encodings and the operand width.
// ----------------------------------------------------------------------------
package alu4_arbiter_pkg;

    localparam int DATA_W = 4;

    // Opcode encodings seen on reqN_sel and on the ALU select input.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage : alu4_arbiter_pkg

// File: rtl/alu4_arbiter_alu4bit.sv
// ----------------------------------------------------------------------------
// alu4bit
//   Purely combinational 4-bit ALU shared by both requesters.
//   Ports:
//     i_a, i_b  [3:0]  operands
//     i_cin            carry-in, used by ADD only
//     i_sel     [1:0]  opcode (AND / OR / XOR / ADD)
//     o_y       [3:0]  result, (a+b+cin) mod 16 for ADD
//     o_cout           carry-out of ADD, forced 0 for logic ops
// ----------------------------------------------------------------------------
module alu4bit
    import alu4_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_cin,
    input  logic [1:0]        i_sel,
    output logic [DATA_W-1:0] o_y,
    output logic              o_cout
);

    logic [DATA_W:0] w_sum;

    // One bit wider than the operands so the carry-out lands in the MSB.
    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{DATA_W{1'b0}}, i_cin};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        o_y    = '0;
        o_cout = 1'b0;
        case (op_e'(i_sel))
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_ADD: begin
                o_y    = w_sum[DATA_W-1:0];
                o_cout = w_sum[DATA_W];
            end
            default: ;
        endcase
    end

endmodule : alu4bit

// File: rtl/alu4_arbiter.sv
// ----------------------------------------------------------------------------
// alu4_arbiter
//   Two requesters share one 4-bit ALU. In IDLE one valid requester is
//   granted (round-robin pointer breaks ties), its operands are latched,
//   the ALU runs for one EXEC cycle and the registered result is held in
//   RESP until the consumer takes it.
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     reqN_valid / reqN_ready        request handshake, N = 0, 1
//     reqN_a, reqN_b [3:0]           operands
//     reqN_cin, reqN_sel [1:0]       carry-in and opcode
//     rsp_valid / rsp_ready          response handshake
//     rsp_id, rsp_y [3:0], rsp_cout  response owner, result, carry-out
//     busy                           high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module alu4_arbiter
    import alu4_arbiter_pkg::*;
#(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_cin,
    input  logic [1:0]        req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_cin,
    input  logic [1:0]        req1_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_cout,
    output logic              busy
);

    state_e            r_state;
    state_e            w_next_state;
    logic              r_prio;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_cin;
    logic [1:0]        r_sel;
    logic              r_id;
    logic [DATA_W-1:0] r_rsp_y;
    logic              r_rsp_cout;
    logic              r_rsp_id;
    logic              w_grant_id;
    logic              w_accept;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_alu_cout;

    // A sole valid requester wins outright; the pointer only breaks ties.
    always_comb begin
        w_grant_id = r_prio;
        if (req0_valid && !req1_valid) begin
            w_grant_id = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_grant_id = 1'b1;
        end
    end

    // rst_n is folded in so neither ready can rise while reset is held.
    assign w_accept   = rst_n && (r_state == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = w_accept && !w_grant_id;
    assign req1_ready = w_accept &&  w_grant_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_next_state = ST_EXEC;
            ST_EXEC:                w_next_state = ST_RESP;
            ST_RESP: if (rsp_ready) w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: all datapath registers are reset, so the response cannot show
    // stale data and an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= PRIO_INIT;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_sel      <= 2'b00;
            r_id       <= 1'b0;
            r_rsp_y    <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_id   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= w_grant_id ? req1_a   : req0_a;
                r_b    <= w_grant_id ? req1_b   : req0_b;
                r_cin  <= w_grant_id ? req1_cin : req0_cin;
                r_sel  <= w_grant_id ? req1_sel : req0_sel;
                r_id   <= w_grant_id;
                // Next tie goes to whoever was just passed over.
                r_prio <= ~w_grant_id;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_y    <= w_alu_y;
                r_rsp_cout <= w_alu_cout;
                r_rsp_id   <= r_id;
            end
        end
    end

    alu4bit u_alu (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_cin  (r_cin),
        .i_sel  (r_sel),
        .o_y    (w_alu_y),
        .o_cout (w_alu_cout)
    );

    assign rsp_valid = (r_state == ST_RESP);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_y     = r_rsp_y;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_id    = r_rsp_id;

endmodule : alu4_arbiter

// File: tb/tb_alu4_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu4_arbiter
//   Directed bench for alu4_arbiter with hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_alu4_arbiter;
    import alu4_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_cin = 1'b0, req1_cin = 1'b0;
    logic [1:0] req0_sel = '0, req1_sel = '0;
    logic       rsp_valid, rsp_id, rsp_cout, busy;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_y;

    int n_tests = 0;
    int n_fail  = 0;

    alu4_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [3:0] a, input logic [3:0] b,
                            input logic cin, input logic [1:0] sel);
        req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin; req0_sel = sel;
    endtask

    task automatic set_req1(input logic v, input logic [3:0] a, input logic [3:0] b,
                            input logic cin, input logic [1:0] sel);
        req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin; req1_sel = sel;
    endtask

    // Called mid-cycle in IDLE with valids set up; rsp_ready assumed high.
    task automatic run_txn(input string tag, input logic exp_id, input logic [3:0] exp_y,
                           input logic exp_cout, input logic drop);
        check({tag, "_rdy_win"},  8'(exp_id ? req1_ready : req0_ready), 8'd1);
        check({tag, "_rdy_lose"}, 8'(exp_id ? req0_ready : req1_ready), 8'd0);
        step();                              // transfer edge -> EXEC
        if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        #1;
        check({tag, "_exec_busy"},  8'(busy), 8'd1);
        check({tag, "_exec_rspv"},  8'(rsp_valid), 8'd0);
        check({tag, "_exec_rdys"},  8'({req0_ready, req1_ready}), 8'd0);
        step();                              // EXEC -> RESP
        check({tag, "_rspv"}, 8'(rsp_valid), 8'd1);
        check({tag, "_id"},   8'(rsp_id), 8'(exp_id));
        check({tag, "_y"},    8'(rsp_y), 8'(exp_y));
        check({tag, "_cout"}, 8'(rsp_cout), 8'(exp_cout));
        step();                              // RESP consumed -> IDLE
        check({tag, "_idle_busy"}, 8'(busy), 8'd0);
    endtask

    initial begin
        // Reset with both requesters already valid (contention from reset).
        set_req0(1'b1, 4'h3, 4'h5, 1'b0, OP_ADD);   // 3+5 = 8
        set_req1(1'b1, 4'hC, 4'hA, 1'b1, OP_XOR);   // C^A = 6, cin ignored
        #2;
        check("rst_rspv",  8'(rsp_valid), 8'd0);
        check("rst_busy",  8'(busy), 8'd0);
        check("rst_y",     8'(rsp_y), 8'd0);
        check("rst_cout",  8'(rsp_cout), 8'd0);
        check("rst_id",    8'(rsp_id), 8'd0);
        check("rst_rdys",  8'({req0_ready, req1_ready}), 8'd0);
        step();
        check("rst_held_busy", 8'(busy), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Contention: strict alternation 0,1,0,1 with both held valid.
        run_txn("cont0", 1'b0, 4'h8, 1'b0, 1'b0);
        run_txn("cont1", 1'b1, 4'h6, 1'b0, 1'b0);
        run_txn("cont2", 1'b0, 4'h8, 1'b0, 1'b0);
        run_txn("cont3", 1'b1, 4'h6, 1'b0, 1'b1);

        // Single ops.
        set_req0(1'b1, 4'b1010, 4'b0011, 1'b0, OP_AND); #1;
        run_txn("and", 1'b0, 4'b0010, 1'b0, 1'b1);
        set_req1(1'b1, 4'hF, 4'h1, 1'b1, OP_ADD); #1;
        run_txn("add_c", 1'b1, 4'h1, 1'b1, 1'b1);
        set_req1(1'b1, 4'hF, 4'h1, 1'b1, OP_XOR); #1;
        run_txn("xor_cin", 1'b1, 4'hE, 1'b0, 1'b1);
        set_req0(1'b1, 4'h7, 4'h8, 1'b1, OP_ADD); #1;    // 7+8+1 = 0x10
        run_txn("add_wrap", 1'b0, 4'h0, 1'b1, 1'b1);
        set_req0(1'b1, 4'b1010, 4'b0101, 1'b1, OP_OR); #1;
        run_txn("or", 1'b0, 4'hF, 1'b0, 1'b1);

        // Backpressure: pointer now favours req1 (last grant was req0).
        rsp_ready = 1'b0;
        set_req0(1'b1, 4'h1, 4'h1, 1'b0, OP_AND);
        set_req1(1'b1, 4'h6, 4'h3, 1'b0, OP_ADD);        // 6+3 = 9
        #1;
        check("bp_rdy1", 8'(req1_ready), 8'd1);
        check("bp_rdy0", 8'(req0_ready), 8'd0);
        step();
        req1_valid = 1'b0;                               // req0 stays valid
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_rspv", 8'(rsp_valid), 8'd1);
            check("bp_y",    8'(rsp_y), 8'h9);
            check("bp_id",   8'(rsp_id), 8'd1);
            check("bp_cout", 8'(rsp_cout), 8'd0);
            check("bp_busy", 8'(busy), 8'd1);
            check("bp_rdys", 8'({req0_ready, req1_ready}), 8'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp_done_rspv", 8'(rsp_valid), 8'd0);
        check("bp_done_busy", 8'(busy), 8'd0);
        check("bp_done_rdy0", 8'(req0_ready), 8'd1);
        req0_valid = 1'b0;

        // Reset during EXEC: abort, no response, pointer back to PRIO_INIT.
        #1;
        set_req0(1'b1, 4'hF, 4'hF, 1'b1, OP_ADD); #1;
        step();                                          // accepted, EXEC
        check("mid_exec_busy", 8'(busy), 8'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 8'(busy), 8'd0);
        check("mid_rst_rspv", 8'(rsp_valid), 8'd0);
        check("mid_rst_out",  8'({rsp_id, rsp_cout, rsp_y}), 8'd0);
        check("mid_rst_rdys", 8'({req0_ready, req1_ready}), 8'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_rspv", 8'(rsp_valid), 8'd0);
            check("post_rst_busy", 8'(busy), 8'd0);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("post_rst_prio0", 8'(req0_ready), 8'd1);
        check("post_rst_prio1", 8'(req1_ready), 8'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Idle noise on rsp_ready.
        for (int i = 0; i < 6; i++) begin
            rsp_ready = ~rsp_ready;
            step();
            check("noise_rspv", 8'(rsp_valid), 8'd0);
            check("noise_busy", 8'(busy), 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu4_arbiter
